fetch_buffer: RTL and testbench

Parametrised, decoupled instruction-fetch front end that replaces the fixed 12-bit, unbuffered fetch stage between instruction memory and the backend. It owns the PC and issues one read per cycle to a synchronous-read instruction memory. Returned words are queued with their addresses in a DEPTH-entry ring buffer, which absorbs backend stalls. Restart flushes all buffered and in-flight fetches and redirects the PC.

---
 rtl/fetch_buffer_pkg.sv | 22 ++
 rtl/fetch_ring.sv | 72 +++++++
 rtl/fetch_buffer.sv | 99 +++++++++
 tb/tb_fetch_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared fetch front-end types and default widths.
// The backend imports fetch_entry_s to decode queue entries.
package fetch_buffer_pkg;

   localparam int unsigned I_WIDTH_DEF = 12;
   localparam int unsigned A_WIDTH_DEF = 8;
   localparam int unsigned DEPTH_DEF   = 4;

   typedef struct packed {
      logic [A_WIDTH_DEF-1:0] addr;
      logic [I_WIDTH_DEF-1:0] data;
   } fetch_entry_s;

   // Room for one more request given buffered plus in-flight entries.
   function automatic logic has_credit(
      input int unsigned used,
      input int unsigned depth
   );
      return used < depth;
   endfunction

endpackage

// File: rtl/fetch_ring.sv
// DEPTH-entry ring buffer of fetch entries.
// Flush empties it in one cycle and wins over push and pop.
module fetch_ring
   import fetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH   = DEPTH_DEF,
   parameter type         entry_t = fetch_entry_s
) (
   input  logic                       clk,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  entry_t                     entry_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output entry_t                     head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic            pop_ok;
   logic            push_ok;

   // Pointer and occupancy next-state; pops on an empty ring are dropped.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      pop_ok  = pop_i && (count_q != '0) && !flush_i;
      push_ok = push_i && !flush_i;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push_ok) tail_d = tail_q + 1'b1;
         if (pop_ok)  head_d = head_q + 1'b1;
         count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage, cleared on reset so the head reads zero.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         mem_q <= '{default: '0};
      end else if (push_ok) begin
         mem_q[tail_q] <= entry_i;
      end
   end

   assign head_o  = mem_q[head_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// Decoupled fetch front end: PC, issue credit, in-flight tag, restart.
// Returned words are queued with their address in fetch_ring.
module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter int unsigned I_WIDTH = I_WIDTH_DEF,
   parameter int unsigned A_WIDTH = A_WIDTH_DEF,
   parameter int unsigned DEPTH   = DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       reset_i,
   input  logic                       restart_i,
   input  logic [A_WIDTH-1:0]         restart_addr_i,
   input  logic                       deque_i,
   output logic                       imem_rd_o,
   output logic [A_WIDTH-1:0]         imem_addr_o,
   input  logic [I_WIDTH-1:0]         imem_data_i,
   output logic [I_WIDTH-1:0]         instruction_data_o,
   output logic [A_WIDTH-1:0]         instruction_addr_o,
   output logic                       instruction_ready_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [A_WIDTH-1:0] addr;
      logic [I_WIDTH-1:0] data;
   } entry_t;

   logic [A_WIDTH-1:0] pc_q, pc_d;
   logic [A_WIDTH-1:0] tag_q, tag_d;
   logic               inflight_q, inflight_d;
   logic               issue;
   logic               push;
   logic               pop;
   logic [CW-1:0]      count;
   entry_t             push_entry;
   entry_t             head;

   // Issue only while buffered plus in-flight entries leave a free slot.
   always_comb begin
      issue = !reset_i && !restart_i &&
              has_credit(int'(count) + int'(inflight_q), DEPTH);
      push  = inflight_q && !restart_i;
      pop   = deque_i && (count != '0) && !restart_i;
      push_entry.addr = tag_q;
      push_entry.data = imem_data_i;
   end

   // PC, in-flight flag and tag next-state; restart redirects and drops.
   always_comb begin
      pc_d       = pc_q;
      tag_d      = tag_q;
      inflight_d = 1'b0;
      if (restart_i) begin
         pc_d = restart_addr_i;
      end else if (issue) begin
         pc_d       = pc_q + 1'b1;
         tag_d      = pc_q;
         inflight_d = 1'b1;
      end
   end

   // Fetch control registers.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         pc_q       <= '0;
         tag_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         tag_q      <= tag_d;
         inflight_q <= inflight_d;
      end
   end

   fetch_ring #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_ring (
      .clk     (clk),
      .rst_i   (reset_i),
      .push_i  (push),
      .entry_i (push_entry),
      .pop_i   (pop),
      .flush_i (restart_i),
      .head_o  (head),
      .count_o (count)
   );

   assign imem_rd_o           = issue;
   assign imem_addr_o         = pc_q;
   assign instruction_data_o  = head.data;
   assign instruction_addr_o  = head.addr;
   assign instruction_ready_o = (count != '0);
   assign count_o             = count;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: vector table, directed
// corner sequences and random traffic against a queue model.
module tb_fetch_buffer;

   localparam int IW = 12;
   localparam int AW = 8;
   localparam int D  = 4;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset_i = 1'b0;
   logic          restart_i = 1'b0;
   logic [AW-1:0] restart_addr_i = '0;
   logic          deque_i = 1'b0;
   logic          imem_rd_o;
   logic [AW-1:0] imem_addr_o;
   logic [IW-1:0] imem_data_i = '0;
   logic [IW-1:0] instruction_data_o;
   logic [AW-1:0] instruction_addr_o;
   logic          instruction_ready_o;
   logic [CW-1:0] count_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_buffer #(.I_WIDTH(IW), .A_WIDTH(AW), .DEPTH(D)) dut (
      .clk                 (clk),
      .reset_i             (reset_i),
      .restart_i           (restart_i),
      .restart_addr_i      (restart_addr_i),
      .deque_i             (deque_i),
      .imem_rd_o           (imem_rd_o),
      .imem_addr_o         (imem_addr_o),
      .imem_data_i         (imem_data_i),
      .instruction_data_o  (instruction_data_o),
      .instruction_addr_o  (instruction_addr_o),
      .instruction_ready_o (instruction_ready_o),
      .count_o             (count_o)
   );

   function automatic logic [IW-1:0] memf(input logic [AW-1:0] a);
      return IW'(a) + 12'h100;
   endfunction

   // Synchronous-read memory; junk when no request was made.
   always @(posedge clk)
      imem_data_i <= imem_rd_o ? memf(imem_addr_o) : IW'($urandom);

   // Reference model: queue of buffered addresses, one pending fetch.
   logic [AW-1:0] mq[$];
   bit            m_pend;
   logic [AW-1:0] m_tag;
   logic [AW-1:0] m_pc;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  n, act, exp, $time);
      end
   endtask

   function automatic bit exp_rd(input bit rs);
      return !rs && (mq.size() + int'(m_pend) < D);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pend = 1'b0;
      m_tag  = '0;
      m_pc   = '0;
   endtask

   task automatic drive(input bit rs, input logic [AW-1:0] ra,
                        input bit dq);
      restart_i      = rs;
      restart_addr_i = ra;
      deque_i        = dq;
      #1;
   endtask

   task automatic model_check();
      chk("count", 32'(count_o), 32'(mq.size()));
      chk("imem_rd", 32'(imem_rd_o), 32'(exp_rd(restart_i)));
      chk("imem_addr", 32'(imem_addr_o), 32'(m_pc));
      chk("ready", 32'(instruction_ready_o), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("head_addr", 32'(instruction_addr_o), 32'(mq[0]));
         chk("head_data", 32'(instruction_data_o), 32'(memf(mq[0])));
      end
   endtask

   task automatic advance();
      bit rd;
      rd = exp_rd(restart_i);
      @(posedge clk);
      if (restart_i) begin
         mq.delete();
         m_pend = 1'b0;
         m_pc   = restart_addr_i;
      end else begin
         if (deque_i && mq.size() > 0) void'(mq.pop_front());
         if (m_pend) mq.push_back(m_tag);
         m_pend = rd;
         if (rd) begin
            m_tag = m_pc;
            m_pc  = m_pc + 1'b1;
         end
      end
      #1;
   endtask

   task automatic step(input bit rs, input logic [AW-1:0] ra,
                       input bit dq);
      drive(rs, ra, dq);
      model_check();
      advance();
   endtask

   task automatic chk_zero(input string n);
      chk({n, "_count"}, 32'(count_o), 0);
      chk({n, "_ready"}, 32'(instruction_ready_o), 0);
      chk({n, "_data"}, 32'(instruction_data_o), 0);
      chk({n, "_addr"}, 32'(instruction_addr_o), 0);
      chk({n, "_rd"}, 32'(imem_rd_o), 0);
      chk({n, "_pc"}, 32'(imem_addr_o), 0);
   endtask

   typedef struct {
      bit dq;
      bit rdy;
      int cnt;
      bit rd;
      int pc;
      int ha;
   } vec_t;

   vec_t tbl[23];

   initial begin
      // Streaming, then a 10-cycle stall, then resume.
      tbl[0]  = '{1, 0, 0, 1,  0,  0};
      tbl[1]  = '{1, 0, 0, 1,  1,  0};
      tbl[2]  = '{1, 1, 1, 1,  2,  0};
      tbl[3]  = '{1, 1, 1, 1,  3,  1};
      tbl[4]  = '{1, 1, 1, 1,  4,  2};
      tbl[5]  = '{1, 1, 1, 1,  5,  3};
      tbl[6]  = '{1, 1, 1, 1,  6,  4};
      tbl[7]  = '{1, 1, 1, 1,  7,  5};
      tbl[8]  = '{0, 1, 1, 1,  8,  6};
      tbl[9]  = '{0, 1, 2, 1,  9,  6};
      tbl[10] = '{0, 1, 3, 0, 10,  6};
      for (int i = 11; i <= 17; i++) tbl[i] = '{0, 1, 4, 0, 10, 6};
      tbl[18] = '{1, 1, 4, 0, 10,  6};
      tbl[19] = '{1, 1, 3, 1, 10,  7};
      tbl[20] = '{1, 1, 2, 1, 11,  8};
      tbl[21] = '{1, 1, 2, 1, 12,  9};
      tbl[22] = '{1, 1, 2, 1, 13, 10};

      #1 reset_i = 1'b1;
      @(posedge clk);
      #1;
      chk_zero("reset");
      reset_i = 1'b0;
      model_reset();

      for (int i = 0; i < 23; i++) begin
         drive(1'b0, '0, tbl[i].dq);
         chk($sformatf("tbl%0d_ready", i),
             32'(instruction_ready_o), 32'(tbl[i].rdy));
         chk($sformatf("tbl%0d_count", i), 32'(count_o), tbl[i].cnt);
         chk($sformatf("tbl%0d_rd", i), 32'(imem_rd_o), 32'(tbl[i].rd));
         chk($sformatf("tbl%0d_pc", i), 32'(imem_addr_o), tbl[i].pc);
         if (tbl[i].rdy) begin
            chk($sformatf("tbl%0d_haddr", i),
                32'(instruction_addr_o), tbl[i].ha);
            chk($sformatf("tbl%0d_hdata", i),
                32'(instruction_data_o), 32'(memf(AW'(tbl[i].ha))));
         end
         model_check();
         advance();
      end

      // Stall until 3 buffered plus one in flight, then restart + deque.
      for (int k = 0; k < 12; k++) begin
         if (mq.size() == 3 && m_pend) break;
         step(1'b0, '0, 1'b0);
      end
      drive(1'b1, 8'h40, 1'b1);
      chk("preA_count", 32'(count_o), 3);
      model_check();
      advance();
      for (int k = 1; k <= 4; k++) begin
         drive(1'b0, '0, 1'b1);
         if (k == 1) begin
            chk("rstA_count", 32'(count_o), 0);
            chk("rstA_rd", 32'(imem_rd_o), 1);
            chk("rstA_pc", 32'(imem_addr_o), 32'h40);
         end
         if (k < 3) chk("rstA_notready", 32'(instruction_ready_o), 0);
         if (k == 3) begin
            chk("rstA_ready", 32'(instruction_ready_o), 1);
            chk("rstA_haddr", 32'(instruction_addr_o), 32'h40);
            chk("rstA_hdata", 32'(instruction_data_o), 32'h140);
         end
         model_check();
         advance();
      end

      // PC wrap through 0xFF -> 0x00.
      step(1'b1, 8'hFE, 1'b0);
      for (int k = 0; k < 7; k++) begin
         drive(1'b0, '0, 1'b1);
         if (k >= 2)
            chk("wrap_haddr", 32'(instruction_addr_o),
                32'(8'(8'hFE + k - 2)));
         model_check();
         advance();
      end

      // Asynchronous reset between edges, mid-stream.
      for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b1);
      #2 reset_i = 1'b1;
      #1;
      chk_zero("areset");
      model_reset();
      @(posedge clk);
      #1;
      chk_zero("areset_hold");
      reset_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, '0, 1'b1);
         if (k == 0) chk("rel_pc", 32'(imem_addr_o), 0);
         if (k == 2) begin
            chk("rel_ready", 32'(instruction_ready_o), 1);
            chk("rel_haddr", 32'(instruction_addr_o), 0);
            chk("rel_hdata", 32'(instruction_data_o), 32'h100);
         end
         model_check();
         advance();
      end

      // Random traffic with varying backend pressure.
      for (int i = 0; i < 600; i++) begin
         int thr;
         thr = (i / 100) % 4;
         step($urandom_range(15) == 0, AW'($urandom),
              $urandom_range(3) < thr);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
